// File: rtl/warp_status_ctrl.sv
// warp_status_ctrl: per-core warp context controller.
// Holds pc/mask/status/age/valid for every warp context, steps each warp
// through launch, issue, long-latency wait, barrier and exit, keeps GTO
// ages and releases the core-wide barrier.
// Optional feature: define WARP_WATCHDOG_EN to build the no-issue watchdog
// that drives hang_detect; without it hang_detect is tied low.
// NUM_WARPS is expected to be a power of two so every id selects a context.
//
// Per-warp state table:
//   state        | meaning
//   WARP_IDLE    | context never launched since reset
//   WARP_READY   | eligible for issue, age counting
//   WARP_WAITING | long-latency op outstanding, waits for writeback
//   WARP_BLOCKED | parked at a barrier until core-wide release
//   WARP_DONE    | exited, context may be relaunched
module warp_status_ctrl #(
   parameter int NUM_WARPS       = 8,
   parameter int AGE_WIDTH       = 8,
   parameter int WATCHDOG_CYCLES = 1024,
   parameter int DATA_WIDTH      = 32,
   parameter int WARP_SIZE       = 32,
   localparam int WARP_ID_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   launch_valid,
   input  logic [WARP_ID_WIDTH-1:0]               launch_warp_id,
   input  logic [DATA_WIDTH-1:0]                  launch_pc,
   input  logic [WARP_SIZE-1:0]                   launch_mask,
   output logic                                   launch_ready,
   input  logic                                   issue_ack,
   input  logic [WARP_ID_WIDTH-1:0]               issue_warp_id,
   input  logic [DATA_WIDTH-1:0]                  issue_next_pc,
   input  logic                                   issue_is_long,
   input  logic                                   issue_is_barrier,
   input  logic                                   issue_is_exit,
   input  logic                                   wb_valid,
   input  logic [WARP_ID_WIDTH-1:0]               wb_warp_id,
   output logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]   ctx_pc,
   output logic [NUM_WARPS-1:0][WARP_SIZE-1:0]    ctx_mask,
   output logic [NUM_WARPS-1:0][2:0]              ctx_status,
   output logic [NUM_WARPS-1:0][AGE_WIDTH-1:0]    ctx_age,
   output logic [NUM_WARPS-1:0]                   ctx_valid,
   output logic                                   barrier_release,
   output logic                                   proto_err,
   output logic                                   hang_detect
);

   localparam logic [2:0] WARP_IDLE    = 3'd0;
   localparam logic [2:0] WARP_READY   = 3'd1;
   localparam logic [2:0] WARP_WAITING = 3'd2;
   localparam logic [2:0] WARP_BLOCKED = 3'd3;
   localparam logic [2:0] WARP_DONE    = 3'd4;

   logic [NUM_WARPS-1:0][DATA_WIDTH-1:0] r_pc;
   logic [NUM_WARPS-1:0][WARP_SIZE-1:0]  r_mask;
   logic [NUM_WARPS-1:0][2:0]            r_status;
   logic [NUM_WARPS-1:0][AGE_WIDTH-1:0]  r_age;
   logic [NUM_WARPS-1:0]                 r_valid;
   logic                                 r_barrier_release;
   logic                                 r_proto_err;

   logic       w_launch_ok;
   logic       w_issue_ok;
   logic       w_wb_ok;
   logic       w_any_blocked;
   logic       w_all_blocked;
   logic       w_any_active;
   logic       w_release;
   logic [2:0] w_issue_status;

   assign launch_ready = !r_valid[launch_warp_id] || (r_status[launch_warp_id] == WARP_DONE);
   assign w_launch_ok  = launch_valid && launch_ready;
   assign w_issue_ok   = issue_ack && (r_status[issue_warp_id] == WARP_READY);
   assign w_wb_ok      = wb_valid && (r_status[wb_warp_id] == WARP_WAITING);
   assign w_release    = w_any_blocked && w_all_blocked;

   // Barrier condition from registered state: someone blocked and every live warp blocked.
   always_comb begin
      w_any_blocked = 1'b0;
      w_all_blocked = 1'b1;
      w_any_active  = 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (r_valid[w] && (r_status[w] != WARP_DONE)) begin
            w_any_active = 1'b1;
            if (r_status[w] == WARP_BLOCKED)
               w_any_blocked = 1'b1;
            else
               w_all_blocked = 1'b0;
         end
      end
   end

   // Post-issue state by priority: exit, barrier, long-latency, otherwise stay ready.
   always_comb begin
      w_issue_status = WARP_READY;
      if (issue_is_exit)
         w_issue_status = WARP_DONE;
      else if (issue_is_barrier)
         w_issue_status = WARP_BLOCKED;
      else if (issue_is_long)
         w_issue_status = WARP_WAITING;
   end

   // Per-warp context update; launch, issue, wb and release only ever hit distinct warps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc              <= '0;
         r_mask            <= '0;
         r_status          <= '0;
         r_age             <= '0;
         r_valid           <= '0;
         r_barrier_release <= 1'b0;
         r_proto_err       <= 1'b0;
      end else begin
         r_barrier_release <= w_release;
         if ((issue_ack && !w_issue_ok) || (wb_valid && !w_wb_ok))
            r_proto_err <= 1'b1;
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (w_launch_ok && (launch_warp_id == WARP_ID_WIDTH'(w))) begin
               r_status[w] <= WARP_READY;
               r_pc[w]     <= launch_pc;
               r_mask[w]   <= launch_mask;
               r_age[w]    <= '0;
               r_valid[w]  <= 1'b1;
            end else if (w_issue_ok && (issue_warp_id == WARP_ID_WIDTH'(w))) begin
               r_status[w] <= w_issue_status;
               r_pc[w]     <= issue_next_pc;
               r_age[w]    <= '0;
            end else if (w_wb_ok && (wb_warp_id == WARP_ID_WIDTH'(w))) begin
               r_status[w] <= WARP_READY;
            end else if (w_release && (r_status[w] == WARP_BLOCKED)) begin
               r_status[w] <= WARP_READY;
            end else if ((r_status[w] == WARP_READY) && (r_age[w] != {AGE_WIDTH{1'b1}})) begin
               r_age[w] <= r_age[w] + 1'b1;
            end
         end
      end
   end

`ifdef WARP_WATCHDOG_EN
   localparam int WD_WIDTH = $clog2(WATCHDOG_CYCLES + 1);

   logic [WD_WIDTH-1:0] r_wd_cnt;
   logic                r_hang;

   // Count cycles with live warps but no issue; flag a hang once the threshold is reached.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd_cnt <= '0;
         r_hang   <= 1'b0;
      end else if (issue_ack || !w_any_active) begin
         r_wd_cnt <= '0;
      end else begin
         if (r_wd_cnt != WD_WIDTH'(WATCHDOG_CYCLES))
            r_wd_cnt <= r_wd_cnt + 1'b1;
         if (r_wd_cnt == WD_WIDTH'(WATCHDOG_CYCLES - 1))
            r_hang <= 1'b1;
      end
   end

   assign hang_detect = r_hang;
`else
   logic w_unused_wd;
   assign w_unused_wd = w_any_active | (WATCHDOG_CYCLES == 0);
   assign hang_detect = 1'b0;
`endif

   assign ctx_pc          = r_pc;
   assign ctx_mask        = r_mask;
   assign ctx_status      = r_status;
   assign ctx_age         = r_age;
   assign ctx_valid       = r_valid;
   assign barrier_release = r_barrier_release;
   assign proto_err       = r_proto_err;

endmodule

// File: tb/tb_warp_status_ctrl.sv
// Bench for warp_status_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the warp rules.
module tb_warp_status_ctrl;

   localparam int NW   = 8;
   localparam int AW   = 8;
   localparam int DW   = 32;
   localparam int WS   = 32;
   localparam int IW   = 3;
   localparam int WDC  = 16;
   localparam int AMAX = (1 << AW) - 1;

   localparam int S_IDLE = 0, S_READY = 1, S_WAIT = 2, S_BLK = 3, S_DONE = 4;

   logic                     clk, rst;
   logic                     launch_valid, launch_ready;
   logic [IW-1:0]            launch_warp_id;
   logic [DW-1:0]            launch_pc;
   logic [WS-1:0]            launch_mask;
   logic                     issue_ack, issue_is_long, issue_is_barrier, issue_is_exit;
   logic [IW-1:0]            issue_warp_id;
   logic [DW-1:0]            issue_next_pc;
   logic                     wb_valid;
   logic [IW-1:0]            wb_warp_id;
   logic [NW-1:0][DW-1:0]    ctx_pc;
   logic [NW-1:0][WS-1:0]    ctx_mask;
   logic [NW-1:0][2:0]       ctx_status;
   logic [NW-1:0][AW-1:0]    ctx_age;
   logic [NW-1:0]            ctx_valid;
   logic                     barrier_release, proto_err, hang_detect;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int          m_st[NW];
   logic [31:0] m_pc[NW];
   logic [31:0] m_mask[NW];
   int          m_age[NW];
   bit          m_valid[NW];
   bit          m_perr;
   bit          m_rel;

   warp_status_ctrl #(
      .NUM_WARPS(NW), .AGE_WIDTH(AW), .WATCHDOG_CYCLES(WDC),
      .DATA_WIDTH(DW), .WARP_SIZE(WS)
   ) dut (
      .clk(clk), .rst(rst),
      .launch_valid(launch_valid), .launch_warp_id(launch_warp_id),
      .launch_pc(launch_pc), .launch_mask(launch_mask), .launch_ready(launch_ready),
      .issue_ack(issue_ack), .issue_warp_id(issue_warp_id), .issue_next_pc(issue_next_pc),
      .issue_is_long(issue_is_long), .issue_is_barrier(issue_is_barrier),
      .issue_is_exit(issue_is_exit),
      .wb_valid(wb_valid), .wb_warp_id(wb_warp_id),
      .ctx_pc(ctx_pc), .ctx_mask(ctx_mask), .ctx_status(ctx_status),
      .ctx_age(ctx_age), .ctx_valid(ctx_valid),
      .barrier_release(barrier_release), .proto_err(proto_err), .hang_detect(hang_detect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      launch_valid = 0; launch_warp_id = '0; launch_pc = '0; launch_mask = '0;
      issue_ack = 0; issue_warp_id = '0; issue_next_pc = '0;
      issue_is_long = 0; issue_is_barrier = 0; issue_is_exit = 0;
      wb_valid = 0; wb_warp_id = '0;
   endtask

   task automatic model_reset();
      for (int w = 0; w < NW; w++) begin
         m_st[w] = S_IDLE; m_pc[w] = 0; m_mask[w] = 0; m_age[w] = 0; m_valid[w] = 0;
      end
      m_perr = 0; m_rel = 0;
   endtask

   // One clock of the warp rules, applied to the model from the current inputs.
   task automatic model_step();
      bit any_blk, all_blk, rel, iok, wok, lok;
      int li, ii, wi;
      li = int'(launch_warp_id); ii = int'(issue_warp_id); wi = int'(wb_warp_id);
      any_blk = 0; all_blk = 1;
      for (int w = 0; w < NW; w++) begin
         if (m_valid[w] && m_st[w] == S_BLK) any_blk = 1;
         if (m_valid[w] && m_st[w] != S_DONE && m_st[w] != S_BLK) all_blk = 0;
      end
      rel = any_blk && all_blk;
      lok = launch_valid && (!m_valid[li] || m_st[li] == S_DONE);
      iok = issue_ack && m_st[ii] == S_READY;
      wok = wb_valid && m_st[wi] == S_WAIT;
      if ((issue_ack && !iok) || (wb_valid && !wok)) m_perr = 1;
      for (int w = 0; w < NW; w++)
         if (m_st[w] == S_READY && !(iok && ii == w))
            m_age[w] = (m_age[w] < AMAX) ? m_age[w] + 1 : AMAX;
      for (int w = 0; w < NW; w++)
         if (rel && m_st[w] == S_BLK) m_st[w] = S_READY;
      if (lok) begin
         m_st[li] = S_READY; m_pc[li] = launch_pc; m_mask[li] = launch_mask;
         m_age[li] = 0; m_valid[li] = 1;
      end
      if (iok) begin
         m_pc[ii] = issue_next_pc; m_age[ii] = 0;
         m_st[ii] = issue_is_exit ? S_DONE : issue_is_barrier ? S_BLK :
                    issue_is_long ? S_WAIT : S_READY;
      end
      if (wok) m_st[wi] = S_READY;
      m_rel = rel;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic apply_reset();
      rst = 1; idle_inputs(); model_reset();
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic set_launch(input int id, input logic [31:0] pc, input logic [31:0] mask);
      launch_valid = 1; launch_warp_id = IW'(id); launch_pc = pc; launch_mask = mask;
   endtask

   task automatic set_issue(input int id, input logic [31:0] npc, input bit lng,
                            input bit bar, input bit ex);
      issue_ack = 1; issue_warp_id = IW'(id); issue_next_pc = npc;
      issue_is_long = lng; issue_is_barrier = bar; issue_is_exit = ex;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs(); model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ctx_valid !== '0) begin errors++; $display("FAIL reset_valid got %h exp 0", ctx_valid); end
      checks++; if (ctx_status !== '0) begin errors++; $display("FAIL reset_status got %h exp 0", ctx_status); end
      checks++; if (ctx_pc !== '0 || ctx_mask !== '0 || ctx_age !== '0) begin errors++; $display("FAIL reset_ctx pc/mask/age not zero"); end
      checks++; if ({barrier_release, proto_err, hang_detect} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {barrier_release, proto_err, hang_detect}); end
      checks++; if (launch_ready !== 1'b1) begin errors++; $display("FAIL reset_launch_ready got %b exp 1", launch_ready); end
      rst = 0;
   endtask

   task automatic test_launch();
      apply_reset();
      set_launch(2, 32'h100, 32'hFFFF_FFFF);
      tick();
      checks++; if (ctx_valid[2] !== 1'b1) begin errors++; $display("FAIL launch_valid got %b exp 1", ctx_valid[2]); end
      checks++; if (ctx_status[2] !== 3'(S_READY)) begin errors++; $display("FAIL launch_status got %0d exp %0d", ctx_status[2], S_READY); end
      checks++; if (ctx_pc[2] !== 32'h100) begin errors++; $display("FAIL launch_pc got %h exp 100", ctx_pc[2]); end
      checks++; if (ctx_mask[2] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL launch_mask got %h exp ffffffff", ctx_mask[2]); end
      checks++; if (ctx_age[2] !== 8'd0) begin errors++; $display("FAIL launch_age0 got %0d exp 0", ctx_age[2]); end
      repeat (5) tick();
      checks++; if (ctx_age[2] !== 8'd5) begin errors++; $display("FAIL launch_age5 got %0d exp 5", ctx_age[2]); end
      launch_warp_id = 3'd2; #1;
      checks++; if (launch_ready !== 1'b0) begin errors++; $display("FAIL launch_ready_busy got %b exp 0", launch_ready); end
      launch_warp_id = 3'd3; #1;
      checks++; if (launch_ready !== 1'b1) begin errors++; $display("FAIL launch_ready_free got %b exp 1", launch_ready); end
      idle_inputs();
   endtask

   task automatic test_issue_long();
      apply_reset();
      set_launch(0, 32'h40, 32'hF); tick();
      set_launch(1, 32'h80, 32'hF); tick();
      set_issue(0, 32'h104, 1, 0, 0); tick();
      checks++; if (ctx_status[0] !== 3'(S_WAIT)) begin errors++; $display("FAIL long_status got %0d exp %0d", ctx_status[0], S_WAIT); end
      checks++; if (ctx_pc[0] !== 32'h104 || ctx_age[0] !== 8'd0) begin errors++; $display("FAIL long_pc_age got %h/%0d exp 104/0", ctx_pc[0], ctx_age[0]); end
      checks++; if (ctx_age[1] !== 8'd1) begin errors++; $display("FAIL long_other_age got %0d exp 1", ctx_age[1]); end
      tick();
      checks++; if (ctx_age[0] !== 8'd0 || ctx_age[1] !== 8'd2) begin errors++; $display("FAIL long_hold_age got %0d/%0d exp 0/2", ctx_age[0], ctx_age[1]); end
      wb_valid = 1; wb_warp_id = 3'd0; tick();
      checks++; if (ctx_status[0] !== 3'(S_READY)) begin errors++; $display("FAIL wb_status got %0d exp %0d", ctx_status[0], S_READY); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wb_no_err got %b exp 0", proto_err); end
      tick();
      checks++; if (ctx_age[0] !== 8'd1 || ctx_age[1] !== 8'd4) begin errors++; $display("FAIL wb_age got %0d/%0d exp 1/4", ctx_age[0], ctx_age[1]); end
   endtask

   task automatic test_barrier();
      apply_reset();
      for (int w = 0; w < 4; w++) begin set_launch(w, 32'h1000 + 32'(w), 32'hFF); tick(); end
      for (int w = 0; w < 3; w++) begin set_issue(w, 32'h2000 + 32'(w), 0, 1, 0); tick(); end
      checks++; if (ctx_status[2:0] !== {3'(S_BLK), 3'(S_BLK), 3'(S_BLK)}) begin errors++; $display("FAIL bar_blocked got %h", ctx_status[2:0]); end
      checks++; if (barrier_release !== 1'b0) begin errors++; $display("FAIL bar_early got %b exp 0", barrier_release); end
      set_issue(3, 32'h3000, 0, 0, 1); tick();
      checks++; if (ctx_status[3] !== 3'(S_DONE) || barrier_release !== 1'b0) begin errors++; $display("FAIL bar_exit got %0d/%b exp 4/0", ctx_status[3], barrier_release); end
      checks++; if (ctx_status[0] !== 3'(S_BLK)) begin errors++; $display("FAIL bar_still_blk got %0d exp 3", ctx_status[0]); end
      tick();
      checks++; if (ctx_status[2:0] !== {3'(S_READY), 3'(S_READY), 3'(S_READY)}) begin errors++; $display("FAIL bar_released got %h", ctx_status[2:0]); end
      checks++; if (barrier_release !== 1'b1) begin errors++; $display("FAIL bar_pulse got %b exp 1", barrier_release); end
      tick();
      checks++; if (barrier_release !== 1'b0) begin errors++; $display("FAIL bar_pulse_end got %b exp 0", barrier_release); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL bar_err got %b exp 0", proto_err); end
   endtask

   task automatic test_age_sat();
      apply_reset();
      set_launch(5, 32'h500, 32'h1); tick();
      repeat (254) tick();
      checks++; if (ctx_age[5] !== 8'd254) begin errors++; $display("FAIL age_254 got %0d exp 254", ctx_age[5]); end
      repeat (46) tick();
      checks++; if (ctx_age[5] !== 8'd255) begin errors++; $display("FAIL age_sat got %0d exp 255", ctx_age[5]); end
   endtask

   task automatic test_errors();
      apply_reset();
      set_issue(3, 32'h77, 0, 0, 0); tick();
      checks++; if (proto_err !== 1'b1 || ctx_status[3] !== 3'(S_IDLE)) begin errors++; $display("FAIL err_issue_idle got %b/%0d exp 1/0", proto_err, ctx_status[3]); end
      apply_reset();
      set_launch(0, 32'h10, 32'h3); tick();
      set_launch(1, 32'h20, 32'h3); tick();
      wb_valid = 1; wb_warp_id = 3'd0; tick();
      checks++; if (proto_err !== 1'b1 || ctx_status[0] !== 3'(S_READY)) begin errors++; $display("FAIL err_wb_ready got %b/%0d exp 1/1", proto_err, ctx_status[0]); end
      set_issue(1, 32'h200, 1, 0, 0); tick();
      set_issue(1, 32'h999, 0, 0, 1); tick();
      checks++; if (ctx_status[1] !== 3'(S_WAIT) || ctx_pc[1] !== 32'h200) begin errors++; $display("FAIL err_issue_wait got %0d/%h exp 2/200", ctx_status[1], ctx_pc[1]); end
      set_launch(0, 32'h555, 32'h0); #1;
      checks++; if (launch_ready !== 1'b0) begin errors++; $display("FAIL err_launch_ready got %b exp 0", launch_ready); end
      tick();
      checks++; if (ctx_pc[0] !== 32'h10 || ctx_mask[0] !== 32'h3) begin errors++; $display("FAIL err_launch_busy got %h/%h exp 10/3", ctx_pc[0], ctx_mask[0]); end
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", proto_err); end
   endtask

   task automatic test_watchdog();
      apply_reset();
      set_launch(0, 32'h0, 32'h1); tick();
`ifdef WARP_WATCHDOG_EN
      repeat (WDC - 1) tick();
      checks++; if (hang_detect !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp 0", hang_detect); end
      tick();
      checks++; if (hang_detect !== 1'b1) begin errors++; $display("FAIL wd_fire got %b exp 1", hang_detect); end
      apply_reset();
      set_launch(0, 32'h0, 32'h1); tick();
      repeat (9) tick();
      set_issue(0, 32'h4, 0, 0, 0); tick();
      repeat (WDC - 1) tick();
      checks++; if (hang_detect !== 1'b0) begin errors++; $display("FAIL wd_cleared got %b exp 0", hang_detect); end
`else
      repeat (3 * WDC) tick();
      checks++; if (hang_detect !== 1'b0) begin errors++; $display("FAIL wd_off got %b exp 0", hang_detect); end
`endif
   endtask

   task automatic test_async_reset();
      apply_reset();
      set_launch(4, 32'hABC, 32'hF0); tick();
      set_issue(6, 32'h1, 0, 0, 0); tick();
      rst = 1; #1;
      checks++; if (ctx_valid !== '0 || ctx_status !== '0 || ctx_pc !== '0 || ctx_mask !== '0) begin errors++; $display("FAIL async_rst_ctx valid=%h status=%h", ctx_valid, ctx_status); end
      checks++; if (proto_err !== 1'b0 || hang_detect !== 1'b0) begin errors++; $display("FAIL async_rst_flags got %b%b exp 00", proto_err, hang_detect); end
      @(posedge clk); #1; rst = 0; model_reset();
   endtask

   task automatic test_random();
      int rdy[$];
      int wt[$];
      int id;
      bit exp_lr;
      apply_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         rdy.delete(); wt.delete();
         for (int w = 0; w < NW; w++) begin
            if (m_st[w] == S_READY) rdy.push_back(w);
            if (m_st[w] == S_WAIT) wt.push_back(w);
         end
         if ($urandom_range(2) == 0) set_launch(int'($urandom_range(NW - 1)), $urandom, $urandom);
         if ($urandom_range(1) == 0) begin
            if (rdy.size() > 0 && $urandom_range(9) < 8) id = rdy[$urandom_range(rdy.size() - 1)];
            else id = int'($urandom_range(NW - 1));
            set_issue(id, $urandom, $urandom_range(2) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0);
         end
         if ($urandom_range(2) == 0) begin
            if (wt.size() > 0 && $urandom_range(9) < 8) id = wt[$urandom_range(wt.size() - 1)];
            else id = int'($urandom_range(NW - 1));
            wb_valid = 1; wb_warp_id = IW'(id);
         end
         #1;
         id = int'(launch_warp_id);
         exp_lr = !m_valid[id] || m_st[id] == S_DONE;
         checks++; if (launch_ready !== exp_lr) begin errors++; $display("FAIL rnd_launch_ready cyc %0d got %b exp %b", cyc, launch_ready, exp_lr); end
         tick();
         for (int w = 0; w < NW; w++) begin
            checks++;
            if (ctx_status[w] !== 3'(m_st[w]) || ctx_valid[w] !== m_valid[w] || ctx_pc[w] !== m_pc[w] ||
                ctx_mask[w] !== m_mask[w] || ctx_age[w] !== 8'(m_age[w])) begin
               errors++;
               $display("FAIL rnd_ctx cyc %0d warp %0d got st=%0d v=%b pc=%h age=%0d exp st=%0d v=%b pc=%h age=%0d",
                        cyc, w, ctx_status[w], ctx_valid[w], ctx_pc[w], ctx_age[w],
                        m_st[w], m_valid[w], m_pc[w], m_age[w]);
            end
         end
         checks++; if (barrier_release !== m_rel || proto_err !== m_perr) begin errors++; $display("FAIL rnd_flags cyc %0d got rel=%b err=%b exp rel=%b err=%b", cyc, barrier_release, proto_err, m_rel, m_perr); end
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      model_reset();
      test_reset();
      test_launch();
      test_issue_long();
      test_barrier();
      test_age_sat();
      test_errors();
      test_watchdog();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
